load_unit: RTL and testbench

- Load-side data memory controller for the MEM stage. It is the read counterpart of the store byte-enable path.
- Accepts one load request (lw/lb/lbu/lh/lhu) at a time and issues a word-aligned read to data memory over a req/gnt/rvalid handshake.
- Selects the addressed byte or halfword from the returned word, zero- or sign-extends it, and presents a registered 32-bit result for writeback.
- Holds `ld_ready` low while busy so the pipeline stalls.

---
 rtl/load_unit.sv | 104 ++++++++++
 tb/tb_load_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: MEM-stage load controller; one word-aligned read over req/gnt/rvalid, then byte/half extract and extend.
// Ports: i_clk, i_rst_n (async active-low) | load request i_ld_valid/i_ld_op/i_ld_addr, o_ld_ready
//        memory o_mem_req/o_mem_addr, i_mem_gnt/i_mem_rvalid/i_mem_rdata | result o_rd_valid/o_rd_data/o_rd_err
// Optional: define LOAD_ALIGN_EXC_EN to turn misaligned lw/lh/lhu into an immediate error response.
module load_unit #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_valid,
  input  logic [2:0]  i_ld_op,
  input  logic [31:0] i_ld_addr,
  output logic        o_ld_ready,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_rd_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [1:0]       r_b;
  logic             w_mis;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;
`ifdef LOAD_ALIGN_EXC_EN
  always_comb w_mis = ((i_ld_op == 3'd0 || i_ld_op > 3'd4) && i_ld_addr[1:0] != 2'd0) ||
                      ((i_ld_op == 3'd3 || i_ld_op == 3'd4) && i_ld_addr[0]);
`else
  always_comb w_mis = 1'b0;
`endif
  always_comb begin
    w_byte = r_b == 2'd0 ? i_mem_rdata[7:0] : r_b == 2'd1 ? i_mem_rdata[15:8] :
             r_b == 2'd2 ? i_mem_rdata[23:16] : i_mem_rdata[31:24];
    w_half = r_b[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_ext  = r_op == 3'd1 ? {{24{w_byte[7]}}, w_byte} :
             r_op == 3'd2 ? {24'd0, w_byte} :
             r_op == 3'd3 ? {{16{w_half[15]}}, w_half} :
             r_op == 3'd4 ? {16'd0, w_half} : i_mem_rdata;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= 3'd0;
      r_b        <= 2'd0;
      o_ld_ready <= 1'b1;
      o_mem_req  <= 1'b0;
      o_mem_addr <= 32'd0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= 32'd0;
      o_rd_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_ld_valid) begin
          r_op       <= i_ld_op;
          r_b        <= i_ld_addr[1:0];
          o_mem_addr <= {i_ld_addr[31:2], 2'b00};
          o_ld_ready <= 1'b0;
          if (w_mis) begin
            r_state    <= RESP;
            o_rd_valid <= 1'b1;
            o_rd_data  <= 32'd0;
            o_rd_err   <= 1'b1;
          end else begin
            r_state   <= REQ;
            o_mem_req <= 1'b1;
          end
        end
        REQ: if (i_mem_gnt) begin
          r_state   <= WAIT;
          o_mem_req <= 1'b0;
          r_cnt     <= '0;
        end
        WAIT: if (i_mem_rvalid) begin
          r_state    <= RESP;
          o_rd_valid <= 1'b1;
          o_rd_data  <= w_ext;
          o_rd_err   <= 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          r_state    <= RESP;
          o_rd_valid <= 1'b1;
          o_rd_data  <= 32'd0;
          o_rd_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        RESP: begin
          r_state    <= IDLE;
          o_rd_valid <= 1'b0;
          o_ld_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed checks of load_unit handshake, extraction, timeout, reset abort and alignment option.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        rst_n, valid, gnt, rvalid, t_valid, t_gnt, t_rvalid;
  logic [2:0]  op;
  logic [31:0] addr, rdata;
  logic        ready, req, rd_valid, rd_err;
  logic [31:0] mem_addr, rd_data;
  logic        t_ready, t_req, t_rd_valid, t_rd_err;
  logic [31:0] t_mem_addr, t_rd_data;
  int          total = 0, bad = 0;
  int          lat, reqc, npulse, n;
  logic [31:0] ma;
  always #5 clk = ~clk;
  load_unit u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(valid), .i_ld_op(op), .i_ld_addr(addr),
    .o_ld_ready(ready), .o_mem_req(req), .o_mem_addr(mem_addr), .i_mem_gnt(gnt),
    .i_mem_rvalid(rvalid), .i_mem_rdata(rdata), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_rd_err(rd_err)
  );
  load_unit #(.TIMEOUT_CYC(4), .CNT_W(3)) u_dut_to (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(t_valid), .i_ld_op(op), .i_ld_addr(addr),
    .o_ld_ready(t_ready), .o_mem_req(t_req), .o_mem_addr(t_mem_addr), .i_mem_gnt(t_gnt),
    .i_mem_rvalid(t_rvalid), .i_mem_rdata(rdata), .o_rd_valid(t_rd_valid), .o_rd_data(t_rd_data),
    .o_rd_err(t_rd_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Cycle n counts from 1 after the acceptance edge; gnt is driven in cycle gd+1, rvalid rd cycles later.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input int gd, input int rd,
                     input logic [31:0] d, input bit hold);
    valid = 1'b1; op = o; addr = a; rdata = d; gnt = 1'b0; rvalid = 1'b0;
    tick;
    if (!hold) valid = 1'b0;
    lat = 0; reqc = 0; npulse = 0; ma = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      if (req) begin
        reqc++;
        ma = mem_addr;
      end
      if (rd_valid) begin
        npulse++;
        if (lat == 0) lat = c;
        valid = 1'b0;
      end
      gnt = (c == gd + 1);
      rvalid = (c == gd + 1 + rd);
      tick;
    end
    valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; op = 3'd0; addr = 32'd0; rdata = 32'd0;
    t_valid = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0;
    tick; tick;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_err", 32'(rd_err), 32'd0);
    rst_n = 1'b1;
    tick;
    run(3'd0, 32'h1004, 0, 1, 32'hDEADBEEF, 0);
    chk("lw_addr", ma, 32'h1004);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_pulses", 32'(npulse), 32'd1);
    chk("lw_data", rd_data, 32'hDEADBEEF);
    chk("lw_err", 32'(rd_err), 32'd0);
    run(3'd1, 32'h1003, 0, 1, 32'h80FF1234, 0);
    chk("lb_data", rd_data, 32'hFFFFFF80);
    chk("lb_addr", ma, 32'h1000);
    run(3'd2, 32'h1003, 0, 1, 32'h80FF1234, 0);
    chk("lbu_data", rd_data, 32'h00000080);
    run(3'd3, 32'h1002, 0, 1, 32'h80FF1234, 0);
    chk("lh_data", rd_data, 32'hFFFF80FF);
    run(3'd4, 32'h1000, 0, 1, 32'h80FF1234, 0);
    chk("lhu_data", rd_data, 32'h00001234);
    run(3'd1, 32'h1001, 0, 1, 32'h80FF1234, 0);
    chk("lb_pos", rd_data, 32'h00000012);
    run(3'd7, 32'h2008, 0, 1, 32'hCAFEF00D, 0);
    chk("op7_lw", rd_data, 32'hCAFEF00D);
    run(3'd0, 32'h2000, 3, 5, 32'h12345678, 1);
    chk("dly_reqc", 32'(reqc), 32'd4);
    chk("dly_pulses", 32'(npulse), 32'd1);
    chk("dly_lat", 32'(lat), 32'd10);
    chk("dly_data", rd_data, 32'h12345678);
    run(3'd3, 32'h1001, 0, 1, 32'h80FF1234, 0);
`ifdef LOAD_ALIGN_EXC_EN
    chk("mis_reqc", 32'(reqc), 32'd0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(rd_err), 32'd1);
    chk("mis_data", rd_data, 32'd0);
`else
    chk("mis_addr", ma, 32'h1000);
    chk("mis_lat", 32'(lat), 32'd3);
    chk("mis_err", 32'(rd_err), 32'd0);
    chk("mis_data", rd_data, 32'h00001234);
`endif
    chk("mis_pulses", 32'(npulse), 32'd1);
    valid = 1'b1; op = 3'd0; addr = 32'h3000; gnt = 1'b1;
    tick;
    valid = 1'b0;
    tick;
    gnt = 1'b0;
    tick;
    rst_n = 1'b0;
    #2;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_req", 32'(req), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    rvalid = 1'b1; rdata = 32'hAAAA5555;
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      rvalid = 1'b0;
      if (rd_valid) npulse++;
    end
    chk("arst_pulses", 32'(npulse), 32'd0);
    chk("arst_ready2", 32'(ready), 32'd1);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_data", rd_data, 32'd0);
    chk("arst_err", 32'(rd_err), 32'd0);
    chk("arst_req2", 32'(req), 32'd0);
    t_valid = 1'b1; op = 3'd0; addr = 32'h4000; t_gnt = 1'b1;
    tick;
    t_valid = 1'b0;
    tick;
    t_gnt = 1'b0;
    n = 0;
    while (!t_rd_valid && n < 10) begin
      tick;
      n++;
    end
    chk("to_cycles", 32'(n), 32'd4);
    chk("to_err", 32'(t_rd_err), 32'd1);
    chk("to_data", t_rd_data, 32'd0);
    tick;
    chk("to_ready", 32'(t_ready), 32'd1);
    t_valid = 1'b1; op = 3'd2; addr = 32'h4001; rdata = 32'h0000AB00;
    tick;
    t_valid = 1'b0; t_gnt = 1'b1;
    tick;
    t_gnt = 1'b0; t_rvalid = 1'b1;
    tick;
    t_rvalid = 1'b0;
    chk("to_next_valid", 32'(t_rd_valid), 32'd1);
    chk("to_next_data", t_rd_data, 32'h000000AB);
    chk("to_next_err", 32'(t_rd_err), 32'd0);
    chk("to_next_addr", t_mem_addr, 32'h4000);
    chk("to_next_req", 32'(t_req), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
